// File: rtl/cubehash_core.sv
// rtl/cubehash_core.sv - CubeHash-r/32-h permutation core, one round per clock
module cubehash_core #(
  parameter int ROUNDS    = 16,
  parameter int HASH_BITS = 512
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [255:0]         msg,
  input  logic                 msg_valid,
  input  logic                 final_req,
  output logic                 ready,
  output logic                 busy,
  output logic                 overflow,
  output logic [HASH_BITS-1:0] digest,
  output logic                 digest_valid
);

  localparam int CW = $clog2(10 * ROUNDS + 1);
  localparam logic [CW-1:0] LONG_CNT  = CW'(10 * ROUNDS);
  localparam logic [CW-1:0] SHORT_CNT = CW'(ROUNDS);

  typedef enum logic [2:0] {
    ST_IDLE, ST_INIT, ST_READY, ST_ABSORB, ST_FINAL, ST_DONE
  } state_t;

  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [31:0]            x     [0:31];
  logic [31:0]            x_n   [0:31];
  logic [31:0]            rnd   [0:31];
  logic [31:0]            r     [0:31];
  logic [31:0]            t     [0:31];
  logic                   pend, pend_n;
  logic                   overflow_n;
  logic [HASH_BITS-1:0]   digest_n;
  logic                   digest_valid_n;

  assign ready = (state == ST_READY);
  assign busy  = (state == ST_INIT) || (state == ST_ABSORB) || (state == ST_FINAL);

  // One full CubeHash round applied to the current state; swaps are index-xor permutations
  always_comb begin
    r = x;
    t = x;
    for (int i = 0; i < 16; i++) begin
      r[i+16] = r[i+16] + r[i];
      r[i]    = {r[i][24:0], r[i][31:25]};
    end
    t = r;
    for (int i = 0; i < 16; i++) t[i] = r[i ^ 8];
    r = t;
    for (int i = 0; i < 16; i++) r[i] = r[i] ^ r[i+16];
    t = r;
    for (int i = 16; i < 32; i++) t[i] = r[i ^ 2];
    r = t;
    for (int i = 0; i < 16; i++) begin
      r[i+16] = r[i+16] + r[i];
      r[i]    = {r[i][20:0], r[i][31:21]};
    end
    t = r;
    for (int i = 0; i < 16; i++) t[i] = r[i ^ 4];
    r = t;
    for (int i = 0; i < 16; i++) r[i] = r[i] ^ r[i+16];
    t = r;
    for (int i = 16; i < 32; i++) t[i] = r[i ^ 1];
    rnd = t;
  end

  // Next-state, state-word, counter and output-register decisions
  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    x_n            = x;
    pend_n         = pend;
    overflow_n     = overflow;
    digest_n       = digest;
    digest_valid_n = 1'b0;

    if (msg_valid && (state != ST_READY)) overflow_n = 1'b1;

    case (state)
      ST_IDLE: begin
        if (start) begin
          for (int i = 0; i < 32; i++) x_n[i] = '0;
          x_n[0]     = 32'(HASH_BITS / 8);
          x_n[1]     = 32'd32;
          x_n[2]     = 32'(ROUNDS);
          overflow_n = 1'b0;
          cnt_n      = LONG_CNT;
          state_n    = ST_INIT;
        end
      end
      ST_INIT, ST_ABSORB, ST_FINAL: begin
        x_n   = rnd;
        cnt_n = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          if (state == ST_FINAL) begin
            state_n = ST_DONE;
          end else if ((state == ST_ABSORB) && pend) begin
            // Block and final arrived together: finalise without a READY gap
            x_n[31] = rnd[31] ^ 32'd1;
            pend_n  = 1'b0;
            cnt_n   = LONG_CNT;
            state_n = ST_FINAL;
          end else begin
            state_n = ST_READY;
          end
        end
      end
      ST_READY: begin
        if (start) begin
          for (int i = 0; i < 32; i++) x_n[i] = '0;
          x_n[0]     = 32'(HASH_BITS / 8);
          x_n[1]     = 32'd32;
          x_n[2]     = 32'(ROUNDS);
          overflow_n = 1'b0;
          cnt_n      = LONG_CNT;
          state_n    = ST_INIT;
        end else if (msg_valid) begin
          // Message byte 4i+j lands in byte j (little-endian) of word i
          for (int i = 0; i < 8; i++) begin
            x_n[i] = x[i] ^ {msg[255-32*i-24 -: 8], msg[255-32*i-16 -: 8],
                             msg[255-32*i-8 -: 8],  msg[255-32*i -: 8]};
          end
          pend_n  = final_req;
          cnt_n   = SHORT_CNT;
          state_n = ST_ABSORB;
        end else if (final_req) begin
          x_n[31] = x[31] ^ 32'd1;
          cnt_n   = LONG_CNT;
          state_n = ST_FINAL;
        end
      end
      ST_DONE: begin
        for (int b = 0; b < HASH_BITS / 8; b++) begin
          digest_n[HASH_BITS-1-8*b -: 8] = x[b/4][8*(b%4) +: 8];
        end
        digest_valid_n = 1'b1;
        state_n        = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State register with asynchronous reset of every stored value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      for (int i = 0; i < 32; i++) x[i] <= '0;
      pend         <= 1'b0;
      overflow     <= 1'b0;
      digest       <= '0;
      digest_valid <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      x            <= x_n;
      pend         <= pend_n;
      overflow     <= overflow_n;
      digest       <= digest_n;
      digest_valid <= digest_valid_n;
    end
  end

endmodule

// File: tb/tb_cubehash_core.sv
// tb/tb_cubehash_core.sv - directed self-checking bench for cubehash_core
module tb_cubehash_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start, msg_valid, final_req;
  logic [255:0] msg;
  logic         ready, busy, overflow, digest_valid;
  logic [511:0] digest;

  logic         start_b, msg_valid_b, final_req_b;
  logic [255:0] msg_b;
  logic         ready_b, busy_b, overflow_b, digest_valid_b;
  logic [255:0] digest_b;

  cubehash_core #(.ROUNDS(16), .HASH_BITS(512)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start), .msg(msg), .msg_valid(msg_valid),
    .final_req(final_req), .ready(ready), .busy(busy), .overflow(overflow),
    .digest(digest), .digest_valid(digest_valid)
  );

  cubehash_core #(.ROUNDS(1), .HASH_BITS(256)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .msg(msg_b), .msg_valid(msg_valid_b),
    .final_req(final_req_b), .ready(ready_b), .busy(busy_b), .overflow(overflow_b),
    .digest(digest_b), .digest_valid(digest_valid_b)
  );

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] EMPTY_BLK = {8'h80, 248'h0};
  localparam logic [255:0] ABC_BLK   = {32'h61626380, 224'h0};
  localparam logic [255:0] JUNK_BLK  = {8{32'hdeadbeef}};

  logic [511:0] abc_d;

  // Reference CubeHash state, stepped with explicit swaps
  logic [31:0] m [0:31];

  task automatic m_round();
    logic [31:0] tmp;
    for (int i = 0; i < 16; i++) m[16+i] = m[16+i] + m[i];
    for (int i = 0; i < 16; i++) m[i] = (m[i] << 7) | (m[i] >> 25);
    for (int i = 0; i < 8; i++) begin tmp = m[i]; m[i] = m[i+8]; m[i+8] = tmp; end
    for (int i = 0; i < 16; i++) m[i] = m[i] ^ m[16+i];
    for (int i = 16; i < 32; i++)
      if ((i & 2) == 0) begin tmp = m[i]; m[i] = m[i+2]; m[i+2] = tmp; end
    for (int i = 0; i < 16; i++) m[16+i] = m[16+i] + m[i];
    for (int i = 0; i < 16; i++) m[i] = (m[i] << 11) | (m[i] >> 21);
    for (int i = 0; i < 16; i++)
      if ((i & 4) == 0) begin tmp = m[i]; m[i] = m[i+4]; m[i+4] = tmp; end
    for (int i = 0; i < 16; i++) m[i] = m[i] ^ m[16+i];
    for (int i = 16; i < 32; i += 2) begin tmp = m[i]; m[i] = m[i+1]; m[i+1] = tmp; end
  endtask

  task automatic m_init(input int rr, input int hh);
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    m[0] = hh / 8;
    m[1] = 32;
    m[2] = rr;
    repeat (10 * rr) m_round();
  endtask

  task automatic m_absorb(input logic [255:0] blk, input int rr);
    for (int k = 0; k < 32; k++) m[k/4][8*(k%4) +: 8] = m[k/4][8*(k%4) +: 8] ^ blk[255-8*k -: 8];
    repeat (rr) m_round();
  endtask

  task automatic m_final(input int rr);
    m[31] = m[31] ^ 32'd1;
    repeat (10 * rr) m_round();
  endtask

  function automatic logic [511:0] m_digest(input int hh);
    logic [511:0] d;
    d = '0;
    for (int b = 0; b < hh / 8; b++) d[511-8*b -: 8] = m[b/4][8*(b%4) +: 8];
    return d;
  endfunction

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_block(input logic [255:0] blk, input logic with_final);
    @(negedge clk); msg = blk; msg_valid = 1'b1; final_req = with_final;
    @(negedge clk); msg_valid = 1'b0; final_req = 1'b0;
  endtask

  task automatic pulse_final();
    @(negedge clk); final_req = 1'b1;
    @(negedge clk); final_req = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin n++; @(negedge clk); end
  endtask

  task automatic count_to_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 1000) begin n++; @(negedge clk); end
  endtask

  task automatic count_to_dv(output int n);
    n = 0;
    while (digest_valid !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    checks++; if (digest !== 512'h0) begin errors++; $display("FAIL reset_digest got %h want 0", digest); end
    checks++; if (digest_valid !== 1'b0) begin errors++; $display("FAIL reset_dv got %b want 0", digest_valid); end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL idle_ready got %b want 0", ready); end
  endtask

  task automatic test_empty();
    int n;
    logic [511:0] exp_d;
    m_init(16, 512); m_absorb(EMPTY_BLK, 16); m_final(16); exp_d = m_digest(512);
    pulse_start();
    count_busy(n);
    checks++; if (n !== 160) begin errors++; $display("FAIL init_busy_cycles got %0d want 160", n); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL init_ready got %b want 1", ready); end
    pulse_block(EMPTY_BLK, 1'b0);
    count_to_ready(n);
    pulse_final();
    count_to_dv(n);
    checks++; if (n !== 161) begin errors++; $display("FAIL final_latency got %0d want 161", n); end
    checks++; if (digest !== exp_d) begin errors++; $display("FAIL empty_digest got %h want %h", digest, exp_d); end
    @(negedge clk);
    checks++; if (digest_valid !== 1'b0) begin errors++; $display("FAIL dv_single got %b want 0", digest_valid); end
    checks++; if (digest !== exp_d) begin errors++; $display("FAIL digest_hold got %h want %h", digest, exp_d); end
  endtask

  task automatic test_abc();
    int n;
    m_init(16, 512); m_absorb(ABC_BLK, 16); m_final(16); abc_d = m_digest(512);
    pulse_start();
    count_busy(n);
    pulse_block(ABC_BLK, 1'b0);
    count_to_ready(n);
    checks++; if (n !== 16) begin errors++; $display("FAIL absorb_ready_low got %0d want 16", n); end
    pulse_final();
    count_to_dv(n);
    checks++; if (digest !== abc_d) begin errors++; $display("FAIL abc_digest got %h want %h", digest, abc_d); end
  endtask

  task automatic test_combined();
    int n;
    pulse_start();
    count_busy(n);
    pulse_block(ABC_BLK, 1'b1);
    count_busy(n);
    checks++; if (n !== 176) begin errors++; $display("FAIL combined_busy got %0d want 176", n); end
    @(negedge clk);
    checks++; if (digest_valid !== 1'b1) begin errors++; $display("FAIL combined_dv got %b want 1", digest_valid); end
    checks++; if (digest !== abc_d) begin errors++; $display("FAIL combined_digest got %h want %h", digest, abc_d); end
  endtask

  task automatic test_overflow();
    int n;
    pulse_start();
    count_busy(n);
    pulse_block(ABC_BLK, 1'b0);
    @(negedge clk); msg = JUNK_BLK; msg_valid = 1'b1;
    @(negedge clk); msg_valid = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set got %b want 1", overflow); end
    count_to_ready(n);
    pulse_final();
    count_to_dv(n);
    checks++; if (digest !== abc_d) begin errors++; $display("FAIL overflow_digest got %h want %h", digest, abc_d); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky got %b want 1", overflow); end
    pulse_start();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_clear got %b want 0", overflow); end
  endtask

  task automatic test_reset_mid();
    int n;
    count_busy(n);
    pulse_block(ABC_BLK, 1'b0);
    @(negedge clk); msg_valid = 1'b1;
    @(negedge clk); msg_valid = 1'b0;
    checks++; if (busy !== 1'b1 || overflow !== 1'b1) begin errors++; $display("FAIL pre_reset busy %b ovf %b want 1 1", busy, overflow); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL async_ready got %b want 0", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy got %b want 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL async_overflow got %b want 0", overflow); end
    checks++; if (digest !== 512'h0) begin errors++; $display("FAIL async_digest got %h want 0", digest); end
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (digest_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL post_reset dv %b busy %b want 0 0", digest_valid, busy); end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [255:0] blks [0:2];
    logic [511:0] exp_d;
    blks[0] = {8{32'h01234567}};
    blks[1] = {32'h89abcdef, 32'h00112233, 32'h44556677, 32'h8899aabb, 128'hffeeddcc_bbaa9988_77665544_33221100};
    blks[2] = {32'h78797a80, 224'h0};
    m_init(1, 256);
    for (int i = 0; i < 3; i++) m_absorb(blks[i], 1);
    m_final(1);
    exp_d = m_digest(256);
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    n = 0;
    while (busy_b === 1'b1 && n < 100) begin n++; @(negedge clk); end
    checks++; if (n !== 10) begin errors++; $display("FAIL r1_init_cycles got %0d want 10", n); end
    for (int i = 0; i < 3; i++) begin
      msg_b = blks[i]; msg_valid_b = 1'b1;
      @(negedge clk); msg_valid_b = 1'b0;
      checks++; if (ready_b !== 1'b0) begin errors++; $display("FAIL r1_block%0d_low got %b want 0", i, ready_b); end
      @(negedge clk);
      checks++; if (ready_b !== 1'b1) begin errors++; $display("FAIL r1_block%0d_ready got %b want 1", i, ready_b); end
    end
    final_req_b = 1'b1;
    @(negedge clk); final_req_b = 1'b0;
    n = 0;
    while (digest_valid_b !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++; if (n !== 11) begin errors++; $display("FAIL r1_final_latency got %0d want 11", n); end
    checks++; if (digest_b !== exp_d[511:256]) begin errors++; $display("FAIL r1_digest got %h want %h", digest_b, exp_d[511:256]); end
    @(negedge clk);
    checks++; if (digest_valid_b !== 1'b0) begin errors++; $display("FAIL r1_dv_single got %b want 0", digest_valid_b); end
    checks++; if (overflow_b !== 1'b0) begin errors++; $display("FAIL r1_overflow got %b want 0", overflow_b); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0; msg_valid = 1'b0; final_req = 1'b0; msg = '0;
    start_b = 1'b0; msg_valid_b = 1'b0; final_req_b = 1'b0; msg_b = '0;
    test_reset();
    test_empty();
    test_abc();
    test_combined();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cubehash_core.md
Name: cubehash_core

Overview:
- Consumes the 256-bit message blocks produced by the byte-to-block assembler and runs the CubeHash-r/32-h permutation on the 1024-bit state.
- Sequence per hash: initialise, absorb N blocks, finalise, present digest.
- Executes one round per clock.
- Padding (0x80 then zeros to a 32-byte boundary) is done upstream. This block receives only whole, already-padded blocks.

Parameters:
ROUNDS, 16, rounds per absorbed block (r); init and final each run 10*ROUNDS rounds
HASH_BITS, 512, digest length h in bits; multiple of 8, 8..512

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: begin new hash (initialise state)
msg  in  256  message block; first byte of block in msg[255:248], byte k in msg[255-8k -: 8]
msg_valid  in  1  1-cycle pulse: msg holds a complete block (upstream done strobe)
final  in  1  pulse: finalise after last block
ready  out  1  high when a block or final request can be accepted
busy  out  1  high while rounds are executing (INIT/ABSORB/FINAL)
overflow  out  1  sticky: a block arrived while not ready
digest  out  HASH_BITS  hash result; first output byte in digest[HASH_BITS-1 -: 8]
digest_valid  out  1  1-cycle pulse when digest is updated

Behaviour:
- Reset (async, rst_n=0): state=IDLE, x[0..31]=0, round counter=0, ready=0, busy=0, overflow=0, digest=0, digest_valid=0, pending-final=0.
- State words x[0..31] are 32 bits each. Byte mapping is little-endian: state byte 4i+j = x[i][8j+7:8j].
- FSM states: IDLE, INIT, READY, ABSORB, FINAL, DONE.
- IDLE:
  - start -> load x[0]=HASH_BITS/8, x[1]=32, x[2]=ROUNDS, others 0; go to INIT with counter=10*ROUNDS.
  - msg_valid/final are ignored; msg_valid sets overflow.
- INIT/ABSORB/FINAL:
  - One round per cycle; counter decrements each cycle.
  - When a round is applied with counter==1: INIT and ABSORB go to READY; FINAL goes to DONE.
  - Counter width is clog2(10*ROUNDS+1).
- READY (ready=1):
  - Priority: start > msg_valid > final.
  - start: re-initialise exactly as from IDLE; overflow is cleared.
  - msg_valid: on that edge XOR block byte k into state byte k (k=0..31, i.e. x[0..7]); go to ABSORB with counter=ROUNDS.
  - msg_valid together with final: absorb, and set pending-final. At ABSORB completion go directly to FINAL, skipping READY.
  - final alone: x[31] ^= 1; go to FINAL with counter=10*ROUNDS.
- DONE:
  - For one cycle, digest = state bytes 0..HASH_BITS/8-1; byte 0 goes to the MSBs.
  - digest_valid=1 for exactly that cycle; next state is IDLE.
  - digest holds its value until the next DONE or reset.
- Round: indices are 5-bit with fields n=1bit plus j,k,l,m. Steps in order, all within one cycle:
  1. x[1jklm] += x[0jklm] (mod 2^32)
  2. x[0jklm] rotl 7
  3. swap x[00klm] with x[01klm]
  4. x[0jklm] ^= x[1jklm]
  5. swap x[1jk0m] with x[1jk1m]
  6. x[1jklm] += x[0jklm]
  7. x[0jklm] rotl 11
  8. swap x[0j0lm] with x[0j1lm]
  9. x[0jklm] ^= x[1jklm]
  10. swap x[1jkl0] with x[1jkl1]
- Latency:
  - start accepted at edge T -> ready rises after edge T+10*ROUNDS.
  - Block accepted at T -> ready again after T+ROUNDS.
  - final at T -> digest_valid high in cycle after edge T+10*ROUNDS+1.
- msg_valid outside READY: block dropped, state unchanged, overflow=1 until start or reset.
- start while busy or in DONE: ignored.
- busy=1 exactly in INIT/ABSORB/FINAL.
- Reset mid-operation: immediate return to reset values; no digest_valid.

Test Plan:
1. Reset with rst_n=0 mid-ABSORB -> ready=0, busy=0, digest=0, overflow=0 immediately, without waiting for a clock edge.
2. start at cycle 0, ROUNDS=16 -> busy high 160 cycles, ready rises cycle 161. Then final alone -> digest_valid single pulse 161 cycles later; digest equals the Python CubeHash16/32-512 model of the empty padded message (one block 0x80,0x00...).
3. "abc" padded (msg=0x616263_80_00..00): start, block, final -> digest matches Python model. ready low for exactly 16 cycles after the block.
4. msg_valid and final in the same READY cycle -> 16 ABSORB cycles then 160 FINAL cycles with no READY cycle between. Digest matches scenario 3 when the same block is used.
5. msg_valid pulsed during ABSORB -> overflow=1, digest unchanged versus reference; next start clears overflow to 0.
6. ROUNDS=1, HASH_BITS=256, three blocks back-to-back as soon as ready -> each block accepted, ready low 1 cycle per block. 256-bit digest matches Python model; digest_valid exactly one cycle.
